// File: rtl/score_mem_if.sv
// Handshake, status and RAM-port bundle for the score history scheduler.
// The master side is the environment (game FSM, renderer, RAM macro); the
// slave side is the scheduler itself.
interface score_mem_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          wr_req;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          scan_start;
    logic          scan_busy;
    logic          scan_done;
    logic [DW-1:0] scan_max;
    logic [AW-1:0] head_addr;
    logic [AW:0]   entry_count;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    modport master (
        output wr_req, wr_data, rd_req, rd_addr, scan_start, mem_q,
        input  wr_ack, rd_ack, rd_valid, rd_data, scan_busy, scan_done, scan_max,
               head_addr, entry_count, mem_address, mem_data, mem_wren
    );

    modport slave (
        input  wr_req, wr_data, rd_req, rd_addr, scan_start, mem_q,
        output wr_ack, rd_ack, rd_valid, rd_data, scan_busy, scan_done, scan_max,
               head_addr, entry_count, mem_address, mem_data, mem_wren
    );
endinterface

// File: rtl/score_mem_scheduler.sv
// Single-port score history RAM scheduler. Arbitrates the RAM between game
// writes, renderer reads and an internal high-score scan, keeps the circular
// write pointer and entry count, and pipelines RAM reads back to the renderer.
module score_mem_scheduler #(
    parameter int DEPTH      = 256,
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 4
) (
    input logic        Clock,
    input logic        reset,
    score_mem_if.slave bus
);
    localparam int          SW         = $clog2(STARVE_LIM + 1);
    localparam logic [AW:0] FULL       = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE        = (AW+1)'(1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} scan_state_t;

    scan_state_t   state, state_nxt;
    logic [AW-1:0] head_addr;
    logic [AW:0]   entry_count;
    logic [AW:0]   scan_n;
    logic [AW:0]   scan_addr;
    logic [DW-1:0] run_max, run_max_nxt;
    logic [DW-1:0] scan_max;
    logic          scan_busy;
    logic          scan_done;
    logic [SW-1:0] starve_cnt;
    logic          p1_rd, p1_scan, p2_rd, p2_scan;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    logic scan_pend, starved, start_now, scan_last;
    logic wr_grant, rd_grant, scan_grant;

    // Arbiter: write beats read beats scan, except a starved scan slot beats a read
    always_comb begin
        scan_pend  = (state == ISSUE);
        starved    = scan_pend && (starve_cnt >= STARVE_MAX);
        start_now  = (state == IDLE) && bus.scan_start;
        wr_grant   = reset && bus.wr_req;
        rd_grant   = reset && bus.rd_req && !bus.wr_req && !starved;
        scan_grant = reset && scan_pend && !bus.wr_req && (!bus.rd_req || starved);
        scan_last  = scan_grant && ((scan_addr + ONE) == scan_n);
    end

    // Running max folds in returning scan reads and any write committed during the scan
    always_comb begin
        run_max_nxt = start_now ? '0 : run_max;
        if (p2_scan && (bus.mem_q > run_max_nxt)) begin
            run_max_nxt = bus.mem_q;
        end
        if (wr_grant && (scan_busy || start_now) && (bus.wr_data > run_max_nxt)) begin
            run_max_nxt = bus.wr_data;
        end
    end

    // Scan FSM next state: empty history skips straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.scan_start) state_nxt = (entry_count == '0) ? DONE : ISSUE;
            ISSUE:   if (scan_last) state_nxt = DRAIN;
            DRAIN:   if (!p1_scan && !p2_scan) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Scan FSM state register
    always_ff @(posedge Clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Circular write pointer and saturating entry count
    always_ff @(posedge Clock) begin
        if (!reset) begin
            head_addr   <= '0;
            entry_count <= '0;
        end else if (wr_grant) begin
            head_addr <= head_addr + AW'(1);
            if (entry_count != FULL) entry_count <= entry_count + ONE;
        end
    end

    // Starve counter tracks consecutive read grants that bypassed a pending scan slot
    always_ff @(posedge Clock) begin
        if (!reset || scan_grant || !scan_pend) starve_cnt <= '0;
        else if (rd_grant)                      starve_cnt <= starve_cnt + SW'(1);
    end

    // RAM command register and read-return pipeline (grant, address, q, result)
    always_ff @(posedge Clock) begin
        if (!reset) begin
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            p1_rd       <= 1'b0;
            p1_scan     <= 1'b0;
            p2_rd       <= 1'b0;
            p2_scan     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            mem_wren <= wr_grant;
            mem_data <= wr_grant ? bus.wr_data : '0;
            if (wr_grant)        mem_address <= head_addr;
            else if (rd_grant)   mem_address <= bus.rd_addr;
            else if (scan_grant) mem_address <= scan_addr[AW-1:0];
            p1_rd    <= rd_grant;
            p1_scan  <= scan_grant;
            p2_rd    <= p1_rd;
            p2_scan  <= p1_scan;
            rd_valid <= p2_rd;
            if (p2_rd) rd_data <= bus.mem_q;
        end
    end

    // Scan datapath: snapshot length, walk addresses, publish the result
    always_ff @(posedge Clock) begin
        if (!reset) begin
            scan_n    <= '0;
            scan_addr <= '0;
            run_max   <= '0;
            scan_max  <= '0;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            run_max   <= run_max_nxt;
            case (state)
                IDLE: if (bus.scan_start) begin
                    scan_n    <= entry_count;
                    scan_addr <= '0;
                    scan_busy <= 1'b1;
                end
                ISSUE: if (scan_grant) scan_addr <= scan_addr + ONE;
                DONE: begin
                    scan_max  <= run_max_nxt;
                    scan_done <= 1'b1;
                    scan_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.wr_ack      = wr_grant;
    assign bus.rd_ack      = rd_grant;
    assign bus.rd_valid    = rd_valid;
    assign bus.rd_data     = rd_data;
    assign bus.scan_busy   = scan_busy;
    assign bus.scan_done   = scan_done;
    assign bus.scan_max    = scan_max;
    assign bus.head_addr   = head_addr;
    assign bus.entry_count = entry_count;
    assign bus.mem_address = mem_address;
    assign bus.mem_data    = mem_data;
    assign bus.mem_wren    = mem_wren;
endmodule

// File: tb/tb_score_mem_scheduler.sv
// Self-checking bench for score_mem_scheduler: a cycle-by-cycle vector table
// for write/read/scan basics, plus hand sequences for empty scans, wrap-around,
// scan starvation and mid-scan reset. A behavioural RAM sits on the memory port.
module tb_score_mem_scheduler;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic Clock = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    score_mem_if #(.AW(AW), .DW(DW)) bus ();

    score_mem_scheduler #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .STARVE_LIM(4)) dut (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // Registered-address RAM: q reflects the address latched at the previous edge
    logic [DW-1:0] ram [0:DEPTH-1];
    always @(posedge Clock) begin
        if (bus.mem_wren) ram[bus.mem_address] <= bus.mem_data;
        bus.mem_q <= ram[bus.mem_address];
    end

    // Time limit so a stuck design still ends the run
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic          w;
        logic [31:0]   wd;
        logic          r;
        logic [7:0]    ra;
        logic          ss;
        logic          e_wack;
        logic          e_rack;
        logic          e_wren;
        logic [7:0]    e_maddr;
        logic [31:0]   e_mdata;
        logic          e_rv;
        logic [31:0]   e_rdata;
        logic [7:0]    e_head;
        logic [8:0]    e_cnt;
        logic          e_busy;
        logic          e_done;
        logic [31:0]   e_max;
    } vec_t;

    function automatic vec_t mk(input int w, input int wd, input int r, input int ra, input int ss,
                                input int wack, input int rack, input int wren, input int maddr,
                                input int mdata, input int rv, input int rdata, input int head,
                                input int cnt, input int busy, input int done, input int mx);
        vec_t v;
        v.w = w[0];        v.wd = wd;           v.r = r[0];         v.ra = ra[7:0];
        v.ss = ss[0];      v.e_wack = wack[0];  v.e_rack = rack[0]; v.e_wren = wren[0];
        v.e_maddr = maddr[7:0]; v.e_mdata = mdata; v.e_rv = rv[0];  v.e_rdata = rdata;
        v.e_head = head[7:0];   v.e_cnt = cnt[8:0]; v.e_busy = busy[0]; v.e_done = done[0];
        v.e_max = mx;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge, return at the following negedge
    task automatic applyStimulus(input logic w, input logic [31:0] wd, input logic r,
                                 input logic [7:0] ra, input logic ss);
        @(posedge Clock);
        #1;
        bus.wr_req     = w;
        bus.wr_data    = wd;
        bus.rd_req     = r;
        bus.rd_addr    = ra;
        bus.scan_start = ss;
        @(negedge Clock);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " wr_ack"},      64'(bus.wr_ack),      64'd0);
        checkOutput({tag, " rd_ack"},      64'(bus.rd_ack),      64'd0);
        checkOutput({tag, " rd_valid"},    64'(bus.rd_valid),    64'd0);
        checkOutput({tag, " rd_data"},     64'(bus.rd_data),     64'd0);
        checkOutput({tag, " scan_busy"},   64'(bus.scan_busy),   64'd0);
        checkOutput({tag, " scan_done"},   64'(bus.scan_done),   64'd0);
        checkOutput({tag, " scan_max"},    64'(bus.scan_max),    64'd0);
        checkOutput({tag, " head_addr"},   64'(bus.head_addr),   64'd0);
        checkOutput({tag, " entry_count"}, 64'(bus.entry_count), 64'd0);
        checkOutput({tag, " mem_address"}, 64'(bus.mem_address), 64'd0);
        checkOutput({tag, " mem_data"},    64'(bus.mem_data),    64'd0);
        checkOutput({tag, " mem_wren"},    64'(bus.mem_wren),    64'd0);
    endtask

    task automatic doReset();
        @(posedge Clock);
        #1;
        reset          = 1'b0;
        bus.wr_req     = 1'b0;
        bus.rd_req     = 1'b0;
        bus.scan_start = 1'b0;
        @(posedge Clock);
        #1;
        reset = 1'b1;
    endtask

    // Idle until scan_done pulses or the cycle budget runs out
    task automatic waitScanDone(input string tag, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            idleCycle();
            if (bus.scan_done) seen = 1'b1;
        end
        checkOutput({tag, " scan_done seen"}, 64'(seen), 64'd1);
    endtask

    vec_t vecs[$];

    initial begin
        int acks;
        int dones;

        reset          = 1'b0;
        bus.wr_req     = 1'b0;
        bus.wr_data    = '0;
        bus.rd_req     = 1'b0;
        bus.rd_addr    = '0;
        bus.scan_start = 1'b0;

        // Cycle table: writes 10,50,20; reads 0..2 back-to-back; scan of 3 entries
        //               w  wd  r ra ss wack rack wren maddr mdata rv rdata head cnt busy done max
        vecs.push_back(mk(1, 10, 0, 0, 0, 1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0));
        vecs.push_back(mk(1, 50, 0, 0, 0, 1, 0, 1, 0, 10, 0,  0, 1, 1, 0, 0,  0));
        vecs.push_back(mk(1, 20, 0, 0, 0, 1, 0, 1, 1, 50, 0,  0, 2, 2, 0, 0,  0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 1, 2, 20, 0,  0, 3, 3, 0, 0,  0));
        vecs.push_back(mk(0,  0, 1, 0, 0, 0, 1, 0, 2,  0, 0,  0, 3, 3, 0, 0,  0));
        vecs.push_back(mk(0,  0, 1, 1, 0, 0, 1, 0, 0,  0, 0,  0, 3, 3, 0, 0,  0));
        vecs.push_back(mk(0,  0, 1, 2, 0, 0, 1, 0, 1,  0, 0,  0, 3, 3, 0, 0,  0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 2,  0, 1, 10, 3, 3, 0, 0,  0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 2,  0, 1, 50, 3, 3, 0, 0,  0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 2,  0, 1, 20, 3, 3, 0, 0,  0));
        vecs.push_back(mk(0,  0, 0, 0, 1, 0, 0, 0, 2,  0, 0, 20, 3, 3, 0, 0,  0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 2,  0, 0, 20, 3, 3, 1, 0,  0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 20, 3, 3, 1, 0,  0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 20, 3, 3, 1, 0,  0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 2,  0, 0, 20, 3, 3, 1, 0,  0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 2,  0, 0, 20, 3, 3, 1, 0,  0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 2,  0, 0, 20, 3, 3, 1, 0,  0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 2,  0, 0, 20, 3, 3, 1, 0,  0));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 2,  0, 0, 20, 3, 3, 0, 1, 50));
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 2,  0, 0, 20, 3, 3, 0, 0, 50));

        // Reset state
        @(posedge Clock);
        @(negedge Clock);
        checkAllZero("reset");
        @(posedge Clock);
        #1;
        reset = 1'b1;

        // Empty history: scan_done two cycles after scan_start, max 0
        applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b1);
        checkOutput("empty S busy", 64'(bus.scan_busy), 64'd0);
        idleCycle();
        checkOutput("empty S+1 busy", 64'(bus.scan_busy), 64'd1);
        checkOutput("empty S+1 done", 64'(bus.scan_done), 64'd0);
        idleCycle();
        checkOutput("empty S+2 done", 64'(bus.scan_done), 64'd1);
        checkOutput("empty S+2 busy", 64'(bus.scan_busy), 64'd0);
        checkOutput("empty S+2 max",  64'(bus.scan_max),  64'd0);

        // scan_start with a same-cycle write: snapshot is 0 entries, write still folded in
        applyStimulus(1'b1, 32'd77, 1'b0, 8'd0, 1'b1);
        checkOutput("snap wr_ack", 64'(bus.wr_ack), 64'd1);
        idleCycle();
        checkOutput("snap busy",        64'(bus.scan_busy),   64'd1);
        checkOutput("snap entry_count", 64'(bus.entry_count), 64'd1);
        idleCycle();
        checkOutput("snap done", 64'(bus.scan_done), 64'd1);
        checkOutput("snap max",  64'(bus.scan_max),  64'd77);

        // Table-driven basic sequence
        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            applyStimulus(v.w, v.wd, v.r, v.ra, v.ss);
            checkOutput($sformatf("v%0d wr_ack", i),      64'(bus.wr_ack),      64'(v.e_wack));
            checkOutput($sformatf("v%0d rd_ack", i),      64'(bus.rd_ack),      64'(v.e_rack));
            checkOutput($sformatf("v%0d mem_wren", i),    64'(bus.mem_wren),    64'(v.e_wren));
            checkOutput($sformatf("v%0d mem_address", i), 64'(bus.mem_address), 64'(v.e_maddr));
            checkOutput($sformatf("v%0d mem_data", i),    64'(bus.mem_data),    64'(v.e_mdata));
            checkOutput($sformatf("v%0d rd_valid", i),    64'(bus.rd_valid),    64'(v.e_rv));
            checkOutput($sformatf("v%0d rd_data", i),     64'(bus.rd_data),     64'(v.e_rdata));
            checkOutput($sformatf("v%0d head_addr", i),   64'(bus.head_addr),   64'(v.e_head));
            checkOutput($sformatf("v%0d entry_count", i), 64'(bus.entry_count), 64'(v.e_cnt));
            checkOutput($sformatf("v%0d scan_busy", i),   64'(bus.scan_busy),   64'(v.e_busy));
            checkOutput($sformatf("v%0d scan_done", i),   64'(bus.scan_done),   64'(v.e_done));
            checkOutput($sformatf("v%0d scan_max", i),    64'(bus.scan_max),    64'(v.e_max));
        end

        // 257 writes of value=index: pointer wraps to 1, count saturates, addr 0 holds 256
        doReset();
        acks = 0;
        for (int i = 0; i <= 256; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b0, 8'd0, 1'b0);
            if (bus.wr_ack) acks++;
        end
        idleCycle();
        checkOutput("wrap ack count",  64'(acks),            64'd257);
        checkOutput("wrap head_addr",  64'(bus.head_addr),   64'd1);
        checkOutput("wrap entry_count", 64'(bus.entry_count), 64'd256);
        applyStimulus(1'b0, 32'd0, 1'b1, 8'd0, 1'b0);
        checkOutput("wrap rd_ack", 64'(bus.rd_ack), 64'd1);
        idleCycle();
        idleCycle();
        idleCycle();
        checkOutput("wrap rd_valid", 64'(bus.rd_valid), 64'd1);
        checkOutput("wrap rd_data",  64'(bus.rd_data),  64'd256);
        applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b1);
        waitScanDone("full", 600);
        checkOutput("full scan_max", 64'(bus.scan_max), 64'd256);

        // Continuous reads during a scan: every fifth slot goes to the scan
        applyStimulus(1'b0, 32'd0, 1'b1, 8'd0, 1'b1);
        checkOutput("starve start rd_ack", 64'(bus.rd_ack), 64'd1);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 8'd0, 1'b0);
            checkOutput($sformatf("starve k%0d rd_ack", k), 64'(bus.rd_ack), 64'((k % 5) != 4));
        end
        applyStimulus(1'b1, 32'd999, 1'b1, 8'd0, 1'b0);
        checkOutput("mid-scan wr_ack", 64'(bus.wr_ack),    64'd1);
        checkOutput("mid-scan rd_ack", 64'(bus.rd_ack),    64'd0);
        checkOutput("mid-scan busy",   64'(bus.scan_busy), 64'd1);
        waitScanDone("starve", 1500);
        checkOutput("starve scan_max", 64'(bus.scan_max), 64'd999);

        // Reset in the middle of a scan: everything clears, no scan_done afterwards
        applyStimulus(1'b0, 32'd0, 1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 5; i++) idleCycle();
        checkOutput("abort busy before", 64'(bus.scan_busy), 64'd1);
        @(posedge Clock);
        #1;
        reset = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        checkAllZero("abort");
        @(posedge Clock);
        #1;
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            idleCycle();
            if (bus.scan_done) dones++;
        end
        checkOutput("abort no scan_done", 64'(dones),          64'd0);
        checkOutput("abort busy after",   64'(bus.scan_busy),  64'd0);
        checkOutput("abort scan_max",     64'(bus.scan_max),   64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
